dwa_element_selector: RTL and testbench

Dynamic-element-matching stage directly downstream of the quantizer. It accepts the multi-bit quantized code each sample and drives the enable vector of the unit-element DAC array. Data-weighted averaging (DWA) rotates a pointer through the array, so element mismatch is first-order noise-shaped. A static thermometer mode is selectable for characterisation.

---
 rtl/lib_switchblock_pkg.sv | 21 ++
 rtl/dwa_element_selector_if.sv | 32 +++
 rtl/dwa_thermo_rotate.sv | 32 +++
 rtl/dwa_element_selector.sv | 86 ++++++++
 tb/tb_dwa_element_selector.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/lib_switchblock_pkg.sv
// ============================================================================
// Module  : lib_switchblock_pkg
// Brief   : Shared constants and types for the DAC switch-block library.
// Rev     : 1.0  initial DWA element-selector additions
// ============================================================================
`default_nettype none

package lib_switchblock_pkg;

  localparam int OUTPUT_WIDTH = 3;
  localparam int NUM_ELEMENTS = 2 ** OUTPUT_WIDTH;

  typedef logic [NUM_ELEMENTS-1:0] elem_vec_t;

  localparam logic [7:0] DWA_LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] DWA_LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/dwa_element_selector_if.sv
// ============================================================================
// Module  : dwa_element_selector_if
// Brief   : Code-in / element-enable-out bundle for the DWA element selector.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface dwa_element_selector_if #(
  parameter int OUTPUT_WIDTH = 3,
  parameter int NUM_ELEMENTS = 2 ** OUTPUT_WIDTH
);

  logic [OUTPUT_WIDTH-1:0] code_i;
  logic                    code_valid_i;
  logic                    mode_i;
  logic [NUM_ELEMENTS-1:0] elem_en_o;
  logic                    elem_valid_o;
  logic [OUTPUT_WIDTH-1:0] ptr_o;

  modport master (
    output code_i, code_valid_i, mode_i,
    input  elem_en_o, elem_valid_o, ptr_o
  );

  modport slave (
    input  code_i, code_valid_i, mode_i,
    output elem_en_o, elem_valid_o, ptr_o
  );

endinterface

`default_nettype wire

// File: rtl/dwa_thermo_rotate.sv
// ============================================================================
// Module  : dwa_thermo_rotate
// Brief   : Combinational k-ones mask starting at start_i, wrapping at the top.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dwa_thermo_rotate #(
  parameter int OUTPUT_WIDTH = 3,
  parameter int NUM_ELEMENTS = 2 ** OUTPUT_WIDTH
) (
  input  logic [OUTPUT_WIDTH-1:0] k_i,
  input  logic [OUTPUT_WIDTH-1:0] start_i,
  output logic [NUM_ELEMENTS-1:0] mask_o
);

  localparam int W2 = 2 * NUM_ELEMENTS;
  localparam logic [W2-1:0] c_one = {{(W2-1){1'b0}}, 1'b1};

  logic [W2-1:0] w_ones;
  logic [W2-1:0] w_shift;

  // Shift in a double-width field, then fold the overflow back onto bit 0.
  always_comb begin
    w_ones  = (c_one << k_i) - c_one;
    w_shift = w_ones << start_i;
    mask_o  = w_shift[NUM_ELEMENTS-1:0] | w_shift[W2-1:NUM_ELEMENTS];
  end

endmodule

`default_nettype wire

// File: rtl/dwa_element_selector.sv
// ============================================================================
// Module  : dwa_element_selector
// Brief   : DWA / static-thermometer unit-element selector; optional pointer
//           dither compiled in with macro DWA_DITHER_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dwa_element_selector #(
  parameter int OUTPUT_WIDTH = 3,
  parameter int NUM_ELEMENTS = 2 ** OUTPUT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dwa_element_selector_if.slave  bus
);

  import lib_switchblock_pkg::*;

  logic [NUM_ELEMENTS-1:0] elem_en_q;
  logic [NUM_ELEMENTS-1:0] elem_en_d;
  logic                    elem_valid_q;
  logic [OUTPUT_WIDTH-1:0] ptr_q;
  logic [OUTPUT_WIDTH-1:0] ptr_d;
  logic [OUTPUT_WIDTH-1:0] w_start;
  logic [OUTPUT_WIDTH-1:0] w_step;
  logic [NUM_ELEMENTS-1:0] w_mask;

  assign w_start = bus.mode_i ? '0 : ptr_q;

  dwa_thermo_rotate #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .NUM_ELEMENTS (NUM_ELEMENTS)
  ) u_rotate (
    .k_i     (bus.code_i),
    .start_i (w_start),
    .mask_o  (w_mask)
  );

`ifdef DWA_DITHER_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= DWA_LFSR_SEED;
    end else if (bus.code_valid_i) begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & DWA_LFSR_TAPS)};
    end
  end

  // A zero code never moves the pointer, dither or not.
  assign w_step = (bus.code_i != '0) ? {{(OUTPUT_WIDTH-1){1'b0}}, lfsr_q[0]} : '0;
`else
  assign w_step = '0;
`endif

  always_comb begin
    elem_en_d = elem_en_q;
    ptr_d     = ptr_q;
    if (bus.code_valid_i) begin
      elem_en_d = w_mask;
      if (!bus.mode_i) begin
        ptr_d = ptr_q + bus.code_i + w_step;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      elem_en_q    <= '0;
      elem_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      elem_en_q    <= elem_en_d;
      elem_valid_q <= bus.code_valid_i;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.elem_en_o    = elem_en_q;
  assign bus.elem_valid_o = elem_valid_q;
  assign bus.ptr_o        = ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_dwa_element_selector.sv
// ============================================================================
// Module  : tb_dwa_element_selector
// Brief   : Directed + random scoreboard bench for dwa_element_selector.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dwa_element_selector;

  typedef struct packed {
    logic [7:0] en;
    logic [2:0] ptr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  exp_t       sb[$];
  logic [2:0] m_ptr = '0;
  logic [7:0] m_en  = '0;
  int         usage[8];

  always #5 clk = ~clk;

  dwa_element_selector_if #(.OUTPUT_WIDTH(3), .NUM_ELEMENTS(8)) bus ();

  dwa_element_selector #(
    .OUTPUT_WIDTH (3),
    .NUM_ELEMENTS (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: set bits one by one around the ring.
  function automatic logic [7:0] ref_mask(input logic [2:0] start, input logic [2:0] k);
    logic [7:0] m = '0;
    for (int i = 0; i < int'(k); i++) m[(int'(start) + i) % 8] = 1'b1;
    return m;
  endfunction

  task automatic step(input logic v, input logic [2:0] k, input logic m);
    exp_t e;
    @(negedge clk);
    bus.code_valid_i = v;
    bus.code_i       = k;
    bus.mode_i       = m;
    if (v) begin
      e.en  = ref_mask(m ? 3'd0 : m_ptr, k);
      if (!m) m_ptr = 3'((int'(m_ptr) + int'(k)) % 8);
      e.ptr = m_ptr;
      m_en  = e.en;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v) begin
      chk("elem_valid_hi", 32'(bus.elem_valid_o), 32'd1);
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("elem_en", 32'(bus.elem_en_o), 32'(e.en));
        chk("ptr", 32'(bus.ptr_o), 32'(e.ptr));
      end
    end else begin
      chk("elem_valid_lo", 32'(bus.elem_valid_o), 32'd0);
      chk("elem_en_hold", 32'(bus.elem_en_o), 32'(m_en));
      chk("ptr_hold", 32'(bus.ptr_o), 32'(m_ptr));
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.code_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_en", 32'(bus.elem_en_o), 32'd0);
    chk("rst_valid", 32'(bus.elem_valid_o), 32'd0);
    chk("rst_ptr", 32'(bus.ptr_o), 32'd0);
    #1 rst = 1'b0;
    m_ptr = '0;
    m_en  = '0;
    sb.delete();
  endtask

  initial begin
    logic [2:0] k;
    logic [2:0] old_ptr;
    int mx, mn;
    bus.code_i       = '0;
    bus.code_valid_i = 1'b0;
    bus.mode_i       = 1'b0;

    #3;
    chk("init_en", 32'(bus.elem_en_o), 32'd0);
    chk("init_valid", 32'(bus.elem_valid_o), 32'd0);
    chk("init_ptr", 32'(bus.ptr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 3'd3, 1'b0);
    chk("tp_3a", 32'(bus.elem_en_o), 32'h07);
    step(1'b1, 3'd3, 1'b0);
    chk("tp_3b", 32'(bus.elem_en_o), 32'h38);
    chk("tp_3b_ptr", 32'(bus.ptr_o), 32'd6);
    step(1'b1, 3'd4, 1'b0);
    chk("tp_wrap", 32'(bus.elem_en_o), 32'hC3);
    chk("tp_wrap_ptr", 32'(bus.ptr_o), 32'd2);
    step(1'b1, 3'd7, 1'b0);
    chk("tp_7", 32'(bus.elem_en_o), 32'hFD);
    chk("tp_7_ptr", 32'(bus.ptr_o), 32'd1);
    step(1'b1, 3'd0, 1'b0);
    chk("tp_zero", 32'(bus.elem_en_o), 32'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 3'd5, 1'b1);
    step(1'b1, 3'd5, 1'b1);
    chk("tp_static", 32'(bus.elem_en_o), 32'h1F);
    chk("tp_static_ptr", 32'(bus.ptr_o), 32'd1);
    step(1'b1, 3'd2, 1'b0);
    chk("tp_resume", 32'(bus.elem_en_o), 32'h06);
    chk("tp_resume_ptr", 32'(bus.ptr_o), 32'd3);
    step(1'b1, 3'd0, 1'b1);

    foreach (usage[i]) usage[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      k       = 3'($urandom_range(0, 7));
      old_ptr = m_ptr;
      step(1'b1, k, 1'b0);
      chk("popcount", 32'($countones(bus.elem_en_o)), 32'(k));
      for (int i = 0; i < 8; i++) usage[i] += int'(bus.elem_en_o[i]);
      if (k != 3'd0 && m_ptr <= old_ptr) begin
        mx = usage[0];
        mn = usage[0];
        for (int i = 1; i < 8; i++) begin
          if (usage[i] > mx) mx = usage[i];
          if (usage[i] < mn) mn = usage[i];
        end
        chk("usage_balance", 32'(mx - mn <= 1), 32'd1);
      end
      if (n % 97 == 0) step(1'b0, 3'd0, 1'b0);
    end

    step(1'b1, 3'd6, 1'b0);
    async_reset();
    step(1'b1, 3'd2, 1'b0);
    chk("post_rst", 32'(bus.elem_en_o), 32'h03);
    chk("post_rst_ptr", 32'(bus.ptr_o), 32'd2);
    step(1'b0, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
